pipe_skid_buffer: RTL and testbench
===================================

Name: pipe_skid_buffer

Overview:
- Parametrised successor to the IF/ID pipeline buffer: a 2-entry skid buffer between any two pipeline stages.
- Carries an instruction word and a control word under a valid/ready handshake.
- Adds stall back-pressure, synchronous flush, NOP (bubble) presentation when empty, and a saturating flush-discard counter.
- Intended placement is IF/ID first; it is reusable at ID/EX and EX/MEM by changing widths.

Parameters:
- IW, 16, instruction field width.
- CW, 16, control field width.
- NOP_INSTR, 16'h0000 (IW bits), value driven on out_instr when no valid entry.
- NOP_CTRL, 16'h0000 (CW bits), value driven on out_ctrl when no valid entry.
- DW, 8, width of the flush-discard counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream offers in_instr/in_ctrl.
- in_ready  out  1  buffer can accept an entry this cycle.
- in_instr  in  IW  instruction from upstream stage.
- in_ctrl  in  CW  control word from upstream stage.
- out_valid  out  1  main entry holds valid data.
- out_ready  in  1  downstream accepts; a hazard unit drives it low to stall.
- out_instr  out  IW  main entry instruction, or NOP_INSTR when empty.
- out_ctrl  out  CW  main entry control, or NOP_CTRL when empty.
- flush  in  1  discard all entries (branch taken / exception).
- occupancy  out  2  number of valid entries, 0..2.
- discard_cnt  out  DW  count of valid entries dropped by flush; saturates.

Behaviour:
- State: main entry (instr, ctrl, valid), skid entry (instr, ctrl, valid), discard_cnt.
- Handshake events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !skid.valid. It is a function of registers only; there is no combinational path from out_ready or in_valid.
- out_valid = main.valid. Invariant: skid.valid implies main.valid.
- Outputs are driven from main when valid, otherwise NOP_INSTR/NOP_CTRL.
- Latency: 1 cycle from in_fire to out_valid. Throughput is 1 per cycle while out_ready stays high.
- Update priority: rst > flush > normal.
- rst:
  - Both valids cleared; entry data cleared to NOP values; discard_cnt = 0.
  - Reset outputs: out_valid=0, in_ready=1, occupancy=0, out_instr=NOP_INSTR, out_ctrl=NOP_CTRL.
  - A reset mid-stall or mid-flush has the same effect.
- flush:
  - Both valids cleared next edge; any in_valid in the same cycle is dropped.
  - discard_cnt += (number of valid entries at that edge), saturating at 2^DW-1.
  - in_ready is still driven as !skid.valid during the flush cycle, but no data is captured.
- Normal transitions, by occupancy:
  - occ0:
    - in_fire: load main; occ 1.
    - no in_fire: stay at occ 0.
  - occ1:
    - in_fire & out_fire: main <= input; occ 1.
    - in_fire only: skid <= input; occ 2.
    - out_fire only: clear main.valid; occ 0.
    - neither: hold.
  - occ2 (in_ready=0):
    - out_fire: main <= skid; clear skid.valid; occ 1.
    - else: hold.
- Ordering: entries leave in arrival order; no entry is duplicated or lost except by flush.
- Held entry data and the NOP values are stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared pipeline package holds:
  - default IW/CW constants;
  - NOP_INSTR/NOP_CTRL constants;
  - an entry struct typedef {instr, ctrl, valid} parametrised by width via localparams.
- One natural sub-module: pipe_entry_reg, a single loadable/clearable entry register. It is instantiated twice, as main and skid.
- Occupancy logic, handshake logic and discard_cnt stay in the top.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then inputs idle.
  - Expect: out_valid=0, in_ready=1, occupancy=0, out_instr=16'h0000, discard_cnt=0.
- Streaming:
  - Stimulus: out_ready=1; feed 16'h1111, 16'h2222, 16'h3333 on consecutive cycles.
  - Expect: each appears on out_instr exactly 1 cycle after its in_fire; occupancy stays 1; in_ready never drops.
- Stall fill:
  - Stimulus: out_ready=0; send A=16'hA0A0, then B=16'hB0B0.
  - Expect: occupancy=2 and in_ready=0; C=16'hC0C0 is not accepted while in_ready=0 and must be held at the input.
  - Then raise out_ready: output sequence A, B, C with no loss.
- Flush with full buffer:
  - Stimulus: occupancy=2, assert flush together with in_valid=1 (16'hDEAD).
  - Expect next cycle: occupancy=0, out_instr=NOP, 16'hDEAD never appears, discard_cnt=2.
- Discard counter saturation:
  - Stimulus: DW=2; perform 3 full flushes.
  - Expect: discard_cnt stays at 3 and does not wrap.
- Reset during stall:
  - Stimulus: occupancy=2, out_ready=0, assert rst.
  - Expect next cycle: all reset values; a following in_fire of 16'h0F0F appears after 1 cycle.

Source files
------------

// File: rtl/pipe_skid_buffer_pkg.sv
// Shared pipeline-buffer definitions: default field widths, bubble (NOP)
// encodings, the buffered-entry payload type and a small occupancy helper.
package pipe_skid_buffer_pkg;

  localparam int unsigned PIPE_IW = 16;
  localparam int unsigned PIPE_CW = 16;
  localparam int unsigned PIPE_DW = 8;

  localparam logic [PIPE_IW-1:0] PIPE_NOP_INSTR = 16'h0000;
  localparam logic [PIPE_CW-1:0] PIPE_NOP_CTRL  = 16'h0000;

  // One buffered pipeline entry at the default widths.
  typedef struct packed {
    logic [PIPE_IW-1:0] instr;
    logic [PIPE_CW-1:0] ctrl;
    logic               valid;
  } pipe_entry_t;

  // Number of valid entries held by a two-entry buffer.
  function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
    return 2'(main_v) + 2'(skid_v);
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// Single loadable/clearable pipeline entry register.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   load              capture d_instr/d_ctrl and mark the entry valid
//   clr               drop the entry (valid cleared, data kept)
//   d_instr, d_ctrl   data to capture
//   q_instr, q_ctrl   held data (NOP values after reset)
//   q_valid           entry holds valid data
module pipe_entry_reg
  import pipe_skid_buffer_pkg::*;
#(
  parameter int unsigned    IW        = PIPE_IW,
  parameter int unsigned    CW        = PIPE_CW,
  parameter logic [IW-1:0]  NOP_INSTR = IW'(PIPE_NOP_INSTR),
  parameter logic [CW-1:0]  NOP_CTRL  = CW'(PIPE_NOP_CTRL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clr,
  input  logic [IW-1:0] d_instr,
  input  logic [CW-1:0] d_ctrl,
  output logic [IW-1:0] q_instr,
  output logic [CW-1:0] q_ctrl,
  output logic          q_valid
);

  // Load wins over clear; the parent never asserts both in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_instr <= NOP_INSTR;
      q_ctrl  <= NOP_CTRL;
      q_valid <= 1'b0;
    end else if (load) begin
      q_instr <= d_instr;
      q_ctrl  <= d_ctrl;
      q_valid <= 1'b1;
    end else if (clr) begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer between pipeline stages with valid/ready handshake,
// synchronous flush, NOP presentation when empty and a saturating count of
// entries dropped by flush.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            upstream handshake (in_ready from registers only)
//   in_instr, in_ctrl            upstream payload
//   out_valid/out_ready          downstream handshake (out_ready low = stall)
//   out_instr, out_ctrl          main entry payload or NOP values when empty
//   flush                        drop all entries and any same-cycle input
//   occupancy                    valid entries held, 0..2
//   discard_cnt                  saturating count of entries dropped by flush
module pipe_skid_buffer
  import pipe_skid_buffer_pkg::*;
#(
  parameter int unsigned    IW        = PIPE_IW,
  parameter int unsigned    CW        = PIPE_CW,
  parameter logic [IW-1:0]  NOP_INSTR = IW'(PIPE_NOP_INSTR),
  parameter logic [CW-1:0]  NOP_CTRL  = CW'(PIPE_NOP_CTRL),
  parameter int unsigned    DW        = PIPE_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_instr,
  input  logic [CW-1:0] in_ctrl,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_instr,
  output logic [CW-1:0] out_ctrl,
  input  logic          flush,
  output logic [1:0]    occupancy,
  output logic [DW-1:0] discard_cnt
);

  localparam logic [DW:0] CNT_MAX = {1'b0, {DW{1'b1}}};

  logic          main_v, skid_v;
  logic [IW-1:0] main_instr, skid_instr, main_d_instr;
  logic [CW-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
  logic          main_load, main_clr, skid_load, skid_clr;
  logic          in_fire, out_fire;
  logic [DW:0]   cnt_sum;

  // Handshake derived from registers only.
  assign in_ready  = !skid_v;
  assign out_valid = main_v;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_v & out_ready;
  assign occupancy = occ_count(main_v, skid_v);

  assign out_instr = main_v ? main_instr : NOP_INSTR;
  assign out_ctrl  = main_v ? main_ctrl  : NOP_CTRL;

  // Main refills from skid when skid is occupied, otherwise from the input.
  assign main_d_instr = skid_v ? skid_instr : in_instr;
  assign main_d_ctrl  = skid_v ? skid_ctrl  : in_ctrl;

  // Entry control; flush overrides every load.
  always_comb begin
    main_load = 1'b0;
    main_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else if (skid_v) begin
      main_load = out_fire;
      skid_clr  = out_fire;
    end else if (main_v) begin
      main_load = in_fire & out_fire;
      skid_load = in_fire & !out_fire;
      main_clr  = out_fire & !in_fire;
    end else begin
      main_load = in_fire;
    end
  end

  pipe_entry_reg #(
    .IW(IW), .CW(CW), .NOP_INSTR(NOP_INSTR), .NOP_CTRL(NOP_CTRL)
  ) u_main (
    .clk(clk), .rst(rst), .load(main_load), .clr(main_clr),
    .d_instr(main_d_instr), .d_ctrl(main_d_ctrl),
    .q_instr(main_instr), .q_ctrl(main_ctrl), .q_valid(main_v)
  );

  pipe_entry_reg #(
    .IW(IW), .CW(CW), .NOP_INSTR(NOP_INSTR), .NOP_CTRL(NOP_CTRL)
  ) u_skid (
    .clk(clk), .rst(rst), .load(skid_load), .clr(skid_clr),
    .d_instr(in_instr), .d_ctrl(in_ctrl),
    .q_instr(skid_instr), .q_ctrl(skid_ctrl), .q_valid(skid_v)
  );

  // Saturating flush-discard counter, one extra bit to detect overflow.
  assign cnt_sum = {1'b0, discard_cnt} + (DW+1)'(occupancy);

  always_ff @(posedge clk) begin
    if (rst) begin
      discard_cnt <= '0;
    end else if (flush) begin
      discard_cnt <= (cnt_sum > CNT_MAX) ? {DW{1'b1}} : cnt_sum[DW-1:0];
    end
  end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
module tb_pipe_skid_buffer;
  import pipe_skid_buffer_pkg::*;

  logic        clk, rst, in_valid, out_ready, flush;
  logic [15:0] in_instr, in_ctrl;
  logic        in_ready, out_valid;
  logic [15:0] out_instr, out_ctrl;
  logic [1:0]  occupancy;
  logic [7:0]  discard_cnt;
  logic        in_ready2, out_valid2;
  logic [15:0] out_instr2, out_ctrl2;
  logic [1:0]  occupancy2;
  logic [1:0]  discard_cnt2;

  int tests_run = 0;
  int fails = 0;

  pipe_entry_t model_q[$];
  int          disc8, disc2;

  pipe_skid_buffer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_ctrl(in_ctrl), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_ctrl(out_ctrl),
    .flush(flush), .occupancy(occupancy), .discard_cnt(discard_cnt)
  );

  pipe_skid_buffer #(.DW(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_instr(in_instr), .in_ctrl(in_ctrl), .out_valid(out_valid2),
    .out_ready(out_ready), .out_instr(out_instr2), .out_ctrl(out_ctrl2),
    .flush(flush), .occupancy(occupancy2), .discard_cnt(discard_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    in_instr  = 16'h0;
    in_ctrl   = 16'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push_stalled(input logic [15:0] v);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = v;
    in_ctrl   = ~v;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    tests_run++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    tests_run++;
    if (occupancy !== 2'd0) begin fails++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    tests_run++;
    if (out_instr !== 16'h0000 || out_ctrl !== 16'h0000) begin
      fails++; $display("FAIL reset_nop: got %h/%h expected 0000/0000", out_instr, out_ctrl);
    end
    tests_run++;
    if (discard_cnt !== 8'd0 || discard_cnt2 !== 2'd0) begin
      fails++; $display("FAIL reset_discard: got %0d/%0d expected 0/0", discard_cnt, discard_cnt2);
    end
  endtask

  task automatic test_streaming();
    logic [15:0] vals [3];
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_instr = vals[i];
      in_ctrl  = 16'(i + 1);
      tests_run++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready[%0d]: got %0b expected 1", i, in_ready); end
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_instr !== vals[i] || out_ctrl !== 16'(i + 1)) begin
        fails++; $display("FAIL stream_out[%0d]: got v=%0b %h/%h expected v=1 %h/%h",
                          i, out_valid, out_instr, out_ctrl, vals[i], 16'(i + 1));
      end
      tests_run++;
      if (occupancy !== 2'd1) begin fails++; $display("FAIL stream_occ[%0d]: got %0d expected 1", i, occupancy); end
    end
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      fails++; $display("FAIL stream_drain: got v=%0b occ=%0d expected v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_stall_fill();
    push_stalled(16'hA0A0);
    push_stalled(16'hB0B0);
    tests_run++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      fails++; $display("FAIL stall_full: got occ=%0d rdy=%0b expected occ=2 rdy=0", occupancy, in_ready);
    end
    in_valid = 1'b1;
    in_instr = 16'hC0C0;
    in_ctrl  = 16'h3F3F;
    tick();
    tick();
    tests_run++;
    if (occupancy !== 2'd2 || out_instr !== 16'hA0A0 || out_ctrl !== 16'h5F5F) begin
      fails++; $display("FAIL stall_hold: got occ=%0d %h/%h expected occ=2 a0a0/5f5f", occupancy, out_instr, out_ctrl);
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_instr !== 16'hB0B0 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      fails++; $display("FAIL stall_release_b: got %h occ=%0d rdy=%0b expected b0b0 occ=1 rdy=1", out_instr, occupancy, in_ready);
    end
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (out_instr !== 16'hC0C0 || out_valid !== 1'b1) begin
      fails++; $display("FAIL stall_release_c: got v=%0b %h expected v=1 c0c0", out_valid, out_instr);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      fails++; $display("FAIL stall_drain: got v=%0b occ=%0d expected v=0 occ=0", out_valid, occupancy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush_full();
    do_reset();
    push_stalled(16'h0101);
    push_stalled(16'h0202);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 16'hDEAD;
    in_ctrl  = 16'hBEEF;
    tests_run++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready: got %0b expected 0", in_ready); end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    tests_run++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_instr !== 16'h0000) begin
      fails++; $display("FAIL flush_empty: got occ=%0d v=%0b %h expected occ=0 v=0 0000", occupancy, out_valid, out_instr);
    end
    tests_run++;
    if (discard_cnt !== 8'd2 || discard_cnt2 !== 2'd2) begin
      fails++; $display("FAIL flush_count: got %0d/%0d expected 2/2", discard_cnt, discard_cnt2);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b0 || out_instr === 16'hDEAD) begin
        fails++; $display("FAIL flush_no_dead[%0d]: got v=%0b %h expected v=0 0000", i, out_valid, out_instr);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      push_stalled(16'(k));
      push_stalled(16'(k + 16));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tests_run++;
      if (discard_cnt !== 8'(2 * k) || discard_cnt2 !== 2'((2 * k > 3) ? 3 : 2 * k)) begin
        fails++; $display("FAIL sat_count[%0d]: got %0d/%0d expected %0d/%0d", k, discard_cnt, discard_cnt2,
                          2 * k, (2 * k > 3) ? 3 : 2 * k);
      end
    end
  endtask

  task automatic test_reset_stall();
    push_stalled(16'h1234);
    push_stalled(16'h5678);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_instr !== 16'h0000 ||
        discard_cnt !== 8'd0 || discard_cnt2 !== 2'd0) begin
      fails++; $display("FAIL rst_stall_state: got v=%0b rdy=%0b occ=%0d %h cnt=%0d/%0d expected 0 1 0 0000 0/0",
                        out_valid, in_ready, occupancy, out_instr, discard_cnt, discard_cnt2);
    end
    in_valid = 1'b1;
    in_instr = 16'h0F0F;
    in_ctrl  = 16'h00FF;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_instr !== 16'h0F0F || out_ctrl !== 16'h00FF) begin
      fails++; $display("FAIL rst_stall_refill: got v=%0b %h/%h expected v=1 0f0f/00ff", out_valid, out_instr, out_ctrl);
    end
  endtask

  // Reference: a FIFO of capacity two; flush empties it and adds its size to
  // saturating counters.
  task automatic test_random();
    pipe_entry_t e;
    logic        exp_v, exp_rdy;
    logic [15:0] exp_i, exp_c;
    bit          pop, push;
    do_reset();
    model_q.delete();
    disc8 = 0;
    disc2 = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 5);
      flush     = ($urandom_range(0, 19) == 0);
      in_instr  = 16'($urandom);
      in_ctrl   = 16'($urandom);
      exp_v   = (model_q.size() > 0);
      exp_rdy = (model_q.size() < 2);
      exp_i   = exp_v ? model_q[0].instr : 16'h0000;
      exp_c   = exp_v ? model_q[0].ctrl  : 16'h0000;
      tests_run++;
      if (out_valid !== exp_v || in_ready !== exp_rdy || occupancy !== 2'(model_q.size())) begin
        fails++; $display("FAIL rand_hs[%0d]: got v=%0b rdy=%0b occ=%0d expected v=%0b rdy=%0b occ=%0d",
                          cyc, out_valid, in_ready, occupancy, exp_v, exp_rdy, model_q.size());
      end
      tests_run++;
      if (out_instr !== exp_i || out_ctrl !== exp_c) begin
        fails++; $display("FAIL rand_data[%0d]: got %h/%h expected %h/%h", cyc, out_instr, out_ctrl, exp_i, exp_c);
      end
      tests_run++;
      if (discard_cnt !== 8'(disc8) || discard_cnt2 !== 2'(disc2)) begin
        fails++; $display("FAIL rand_count[%0d]: got %0d/%0d expected %0d/%0d", cyc, discard_cnt, discard_cnt2, disc8, disc2);
      end
      tests_run++;
      if (out_valid2 !== out_valid || in_ready2 !== in_ready || occupancy2 !== occupancy ||
          out_instr2 !== exp_i || out_ctrl2 !== exp_c) begin
        fails++; $display("FAIL rand_dw2[%0d]: got v=%0b rdy=%0b occ=%0d %h/%h expected v=%0b rdy=%0b %h/%h",
                          cyc, out_valid2, in_ready2, occupancy2, out_instr2, out_ctrl2, exp_v, exp_rdy, exp_i, exp_c);
      end
      if (flush) begin
        disc8 = (disc8 + model_q.size() > 255) ? 255 : disc8 + model_q.size();
        disc2 = (disc2 + model_q.size() > 3) ? 3 : disc2 + model_q.size();
        model_q.delete();
      end else begin
        pop  = out_ready && (model_q.size() > 0);
        push = in_valid && (model_q.size() < 2);
        if (pop) void'(model_q.pop_front());
        if (push) begin
          e.instr = in_instr;
          e.ctrl  = in_ctrl;
          e.valid = 1'b1;
          model_q.push_back(e);
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_streaming();
    test_stall_fill();
    test_flush_full();
    test_saturation();
    test_reset_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
